// File: rtl/uart_chargen_fifo.sv
// uart_chargen_fifo: board top level. A character generator fills a small
// first-word-fall-through FIFO with printable ASCII ('!'..'z'). An 8N1 UART
// transmitter drains the FIFO onto uart_tx. A free-running counter steps the
// active-low LEDs as a liveness indicator.
module uart_chargen_fifo #(
    parameter int FIFO_DEPTH     = 16,
    parameter int UART_CDIV      = 434,
    parameter int BLINK_INTERVAL = 50_000_000
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [2:0] dip,
    output logic [2:0] led,
    input  logic       uart_rx,
    output logic       uart_tx
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_W = (UART_CDIV > 1) ? $clog2(UART_CDIV) : 1;
    localparam int BLK_W = (BLINK_INTERVAL > 1) ? $clog2(BLINK_INTERVAL) : 1;

    localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [BIT_W-1:0] BIT_LAST      = BIT_W'(UART_CDIV - 1);
    localparam logic [BLK_W-1:0] BLINK_LAST    = BLK_W'(BLINK_INTERVAL - 1);

    localparam logic [7:0] CHAR_FIRST = 8'h21;
    localparam logic [7:0] CHAR_LAST  = 8'h7A;

    // DIP switches and the receive line are reserved for later use.
    logic unused_inputs;
    assign unused_inputs = ^{dip, uart_rx};

    // ------------------------------------------------------------------
    // FIFO (active-low handshakes, first-word-fall-through)
    // ------------------------------------------------------------------
    logic [7:0]       mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             n_wr;
    logic             n_rd;
    logic             n_full;
    logic             n_empty;
    logic [7:0]       wr_data;
    logic [7:0]       rd_data;
    logic             wr_en;
    logic             rd_en;

    assign n_full  = (count_reg != FIFO_FULL_CNT);
    assign n_empty = (count_reg != '0);
    // Full/empty gating makes the simultaneous read/write corner cases fall out.
    assign wr_en   = !n_wr && n_full;
    assign rd_en   = !n_rd && n_empty;
    assign rd_data = mem_reg[rd_ptr_reg];

    // Storage array; contents need no reset because the count guards them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Character generator
    // ------------------------------------------------------------------
    logic [7:0] char_reg;

    assign n_wr    = ~n_full;
    assign wr_data = char_reg;

    // Advance through '!'..'z' on every accepted write, hold while full.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            char_reg <= CHAR_FIRST;
        end else if (!n_wr) begin
            char_reg <= (char_reg == CHAR_LAST) ? CHAR_FIRST : char_reg + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // UART transmitter
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    uart_state_t      state_reg;
    uart_state_t      state_next;
    logic [BIT_W-1:0] bit_cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       shift_reg;
    logic             bit_tick;

    assign bit_tick = (bit_cnt_reg == BIT_LAST);

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state, one-cycle pop request and line level. The line is decoded
    // from state so reset drives it high without waiting for a clock.
    always_comb begin
        state_next = state_reg;
        n_rd       = 1'b1;
        uart_tx    = 1'b1;
        case (state_reg)
            IDLE: begin
                if (n_empty) begin
                    n_rd       = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                uart_tx = 1'b0;
                if (bit_tick) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                uart_tx = shift_reg[bit_idx_reg];
                if (bit_tick && (bit_idx_reg == 3'd7)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bit timing, bit index and the byte latched at the pop.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt_reg <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
        end else begin
            if (state_reg == IDLE) begin
                bit_cnt_reg <= '0;
                bit_idx_reg <= '0;
            end else begin
                bit_cnt_reg <= bit_tick ? '0 : bit_cnt_reg + 1'b1;
                if ((state_reg == DATA) && bit_tick) begin
                    bit_idx_reg <= bit_idx_reg + 3'd1;
                end
            end
            if (!n_rd) begin
                shift_reg <= rd_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Liveness blinker
    // ------------------------------------------------------------------
    logic [BLK_W-1:0] blink_cnt_reg;
    logic [2:0]       step_reg;

    assign led = ~step_reg;

    // Step the LED pattern once per BLINK_INTERVAL cycles.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            blink_cnt_reg <= '0;
            step_reg      <= '0;
        end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg <= '0;
            step_reg      <= step_reg + 3'd1;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_chargen_fifo.sv
// Testbench for uart_chargen_fifo: decodes the serial line, compares every
// frame against an ASCII sequence model, probes the FIFO flags and LEDs.
module tb_uart_chargen_fifo;

    localparam int DEPTH = 4;
    localparam int CDIV  = 4;
    localparam int BI    = 4;
    localparam int FRAME = 10 * CDIV;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [2:0] dip = 3'b000;
    logic       uart_rx = 1'b1;
    logic [2:0] led;
    logic       uart_tx;

    uart_chargen_fifo #(
        .FIFO_DEPTH    (DEPTH),
        .UART_CDIV     (CDIV),
        .BLINK_INTERVAL(BI)
    ) dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .dip    (dip),
        .led    (led),
        .uart_rx(uart_rx),
        .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] expq[$];

    // decoder / monitor state
    int   rel_cyc = 0;
    bit   in_frame = 0;
    int   sidx = 0;
    logic samp[FRAME];
    int   idle_run = 0;
    bit   first_frame = 1;
    bit   full_seen = 0;
    int   frames_done = 0;
    int   occ_viol = 0;
    int   nwr_viol = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference sequence: byte k after reset is '!' + (k mod 90).
    function automatic logic [7:0] model_byte(input int k);
        return 8'(8'h21 + (k % 90));
    endfunction

    // Rising edges since reset release.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) rel_cyc <= 0;
        else        rel_cyc <= rel_cyc + 1;
    end

    // Monitor: samples away from the active edge, decodes frames, pops scoreboard.
    always @(negedge clk) begin
        if (!n_rst) begin
            in_frame    = 0;
            sidx        = 0;
            idle_run    = 0;
            first_frame = 1;
            full_seen   = 0;
        end else begin
            if (rel_cyc <= 32) check("led", {29'd0, led}, {29'd0, ~3'(rel_cyc / BI)});
            if (dut.count_reg > DEPTH) occ_viol++;
            if (!dut.n_full && dut.n_wr !== 1'b1) nwr_viol++;
            if (!full_seen && dut.n_full === 1'b0) begin
                full_seen = 1;
                check("full_latency_le5", rel_cyc <= 5, 1);
            end
            if (!in_frame) begin
                if (uart_tx === 1'b0) begin
                    in_frame = 1;
                    samp[0]  = 1'b0;
                    sidx     = 1;
                    if (first_frame) check("start_latency", rel_cyc, 2);
                    else             check("frame_gap", idle_run, 1);
                    first_frame = 0;
                end else begin
                    idle_run++;
                end
            end else begin
                samp[sidx] = uart_tx;
                sidx++;
                if (sidx == FRAME) begin
                    bit         shape_ok = 1;
                    logic [7:0] b;
                    for (int k = 0; k < 10; k++)
                        for (int j = 1; j < CDIV; j++)
                            if (samp[k*CDIV+j] !== samp[k*CDIV]) shape_ok = 0;
                    if (samp[0] !== 1'b0 || samp[9*CDIV] !== 1'b1) shape_ok = 0;
                    for (int k = 0; k < 8; k++) b[k] = samp[(k+1)*CDIV];
                    check("frame_shape", shape_ok, 1);
                    check("scoreboard_has_entry", expq.size() > 0, 1);
                    if (expq.size() > 0) begin
                        logic [7:0] e;
                        e = expq.pop_front();
                        $display("frame %0d: byte %02h expected %02h", frames_done, b, e);
                        check("byte", b, e);
                    end
                    frames_done++;
                    in_frame = 0;
                    sidx     = 0;
                    idle_run = 0;
                end
            end
        end
    end

    // Release reset and load the expected byte stream for this run.
    task automatic release_reset();
        expq.delete();
        for (int k = 0; k < 120; k++) expq.push_back(model_byte(k));
        @(posedge clk);
        #1 n_rst = 1'b1;
    endtask

    task automatic run_frames(input int n);
        int base;
        base = frames_done;
        for (int c = 0; c < n * (FRAME + 1) + 50 && frames_done < base + n; c++) @(posedge clk);
        check("frames_received", (frames_done - base) >= n, 1);
    endtask

    task automatic reset_state_checks(input string tag);
        check({tag, "_tx"},      uart_tx,      1);
        check({tag, "_led"},     {29'd0, led}, 32'h7);
        check({tag, "_n_empty"}, dut.n_empty,  0);
        check({tag, "_n_full"},  dut.n_full,   1);
    endtask

    task automatic midframe_reset();
        bit found;
        found = 0;
        repeat ($urandom_range(0, 200)) @(posedge clk);
        for (int c = 0; c < 400 && !found; c++) begin
            @(posedge clk);
            #2;
            if (in_frame && sidx >= CDIV + 1 && sidx < 9 * CDIV - 1 && uart_tx === 1'b0) found = 1;
        end
        check("midframe_point_found", found, 1);
        n_rst = 1'b0;
        #1;
        reset_state_checks("midreset");
        repeat ($urandom_range(2, 5)) @(posedge clk);
        release_reset();
    endtask

    initial begin
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        reset_state_checks("reset");
        release_reset();
        run_frames(95);
        midframe_reset();
        run_frames(10);
        midframe_reset();
        run_frames(6);
        check("occupancy_le_depth_violations", occ_viol, 0);
        check("nwr_high_while_full_violations", nwr_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
